// File: rtl/mytest_pkg.sv
// Shared types and constants for the mt_unpacker byte-to-packet assembler.
package mytest;

    localparam int MT_NUM_BYTES = 5;
    localparam int MT_TAG_W     = 5;

    typedef struct packed {
        logic [MT_NUM_BYTES-1:0][7:0] a;
        logic [MT_TAG_W-1:0]          b;
    } m_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_TAG     = 2'd1,
        ST_RESYNC  = 2'd2
    } mt_state_e;

endpackage

// File: rtl/mt_skid_buf.sv
// Small register FIFO (1 or 2 entries) holding assembled packets.
// Latency 1 (write -> o_vld); o_rdy is high when not full or when popping this cycle.
module mt_skid_buf #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic o_rdy,
    input  T     i_dat,
    output logic o_vld,
    input  logic i_rdy,
    output T     o_dat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [1:0]     r_cnt;
    logic           w_push;
    logic           w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_vld  = (r_cnt != 2'd0);
    // A full buffer can still accept when the head leaves in the same cycle.
    assign o_rdy  = (r_cnt != 2'(DEPTH)) || i_rdy;
    assign o_dat  = r_mem[r_rd_ptr];
    assign w_push = i_vld && o_rdy;
    assign w_pop  = o_vld && i_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mt_unpacker.sv
// Assembles NUM_BYTES payload beats plus one tag beat into an m_t packet; framing errors drop and pulse err.
// Latency 1 from tag beat to m_valid; s_ready falls only in TAG while the output buffer is full.
// Optional MT_UNPACK_PARITY_EN: tag-beat s_data[7] carries even parity over payload and tag.
module mt_unpacker
    import mytest::*;
#(
    parameter int NUM_BYTES = MT_NUM_BYTES,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output m_t          m_pkt,
    output logic        err,
    output logic [15:0] pkt_cnt
);

    localparam int CW = $clog2(NUM_BYTES);

    mt_state_e                  r_state, w_state_nxt;
    logic [CW-1:0]              r_cnt, w_cnt_nxt;
    logic [NUM_BYTES-1:0][7:0]  r_a;
    logic                       r_err, w_err_nxt;
    logic [15:0]                r_pkt_cnt;
    logic                       w_beat;
    logic                       w_byte_we;
    logic                       w_push;
    logic                       w_buf_rdy;
    logic                       w_par_ok;
    logic                       w_unused;
    m_t                         w_pkt;

    assign s_ready   = (r_state != ST_TAG) || w_buf_rdy;
    assign w_beat    = s_valid && s_ready;
    assign w_pkt.a   = r_a;
    assign w_pkt.b   = s_data[MT_TAG_W-1:0];
    assign w_unused  = ^s_data[7:MT_TAG_W];
    assign err       = r_err;
    assign pkt_cnt   = r_pkt_cnt;

`ifdef MT_UNPACK_PARITY_EN
    assign w_par_ok = ~^{r_a, s_data[MT_TAG_W-1:0], s_data[7]};
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_byte_we   = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_COLLECT: if (w_beat) begin
                if (s_last) begin
                    w_err_nxt = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_byte_we = 1'b1;
                    if (r_cnt == CW'(NUM_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_TAG;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_TAG: if (w_beat) begin
                w_state_nxt = ST_COLLECT;
                if (!s_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_RESYNC;
                end else if (!w_par_ok) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            ST_RESYNC: if (w_beat && s_last) w_state_nxt = ST_COLLECT;
            default:   w_state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_COLLECT;
            r_cnt     <= '0;
            r_a       <= '0;
            r_err     <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            if (w_byte_we) r_a[r_cnt] <= s_data;
            if (m_valid && m_ready) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    mt_skid_buf #(
        .DEPTH (OUT_DEPTH),
        .T     (m_t)
    ) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (w_push),
        .o_rdy (w_buf_rdy),
        .i_dat (w_pkt),
        .o_vld (m_valid),
        .i_rdy (m_ready),
        .o_dat (m_pkt)
    );

endmodule

// File: tb/tb_mt_unpacker.sv
// Directed bench for mt_unpacker: single packet, back-pressure, framing errors, parity, mid-packet reset.
module tb_mt_unpacker;
    import mytest::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    m_t          m_pkt;
    logic        err;
    logic [15:0] pkt_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    mt_unpacker #(.NUM_BYTES(5), .OUT_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_pkt(m_pkt),
        .err(err), .pkt_cnt(pkt_cnt)
    );

    function automatic m_t mk(input logic [7:0] b0, b1, b2, b3, b4, input logic [4:0] t);
        m_t p;
        p.a[0] = b0; p.a[1] = b1; p.a[2] = b2; p.a[3] = b3; p.a[4] = b4;
        p.b = t;
        return p;
    endfunction

    function automatic logic [7:0] tag_byte(input m_t p, input bit flip);
        logic par;
        par = ^{p.a, p.b} ^ flip;
        return {par, 2'b00, p.b};
    endfunction

    task automatic send_beat(input logic [7:0] d, input bit l);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_pkt(input m_t p, input bit flip);
        for (int i = 0; i < 5; i++) send_beat(p.a[i], 1'b0);
        send_beat(tag_byte(p, flip), 1'b1);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        n_cmp++; if (m_pkt !== '0) begin n_bad++; $display("FAIL reset_m_pkt: got %h required 0", m_pkt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b required 0", err); end
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        m_t p;
        p = mk(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 5'h0A);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(p.a[i], 1'b0);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b required 0", m_valid); end
        send_beat(tag_byte(p, 1'b0), 1'b1);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: m_valid %b required 1", m_valid); end
        n_cmp++; if (m_pkt !== p) begin n_bad++; $display("FAIL single_pkt: got %h required %h", m_pkt, p); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b required 0", err); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL single_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: m_valid %b required 0", m_valid); end
    endtask

    task automatic test_backpressure();
        m_t p1, p2, p3;
        p1 = mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 5'h01);
        p2 = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 5'h12);
        p3 = mk(8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 5'h1F);
        m_ready = 1'b0;
        send_pkt(p1, 1'b0);
        send_pkt(p2, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(p3.a[i], 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_data = tag_byte(p3, 1'b0); s_last = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready_tag: got %b required 0", s_ready); end
        repeat (2) @(negedge clk);
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready_hold: got %b required 0", s_ready); end
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p1) begin n_bad++; $display("FAIL bp_head_stable: valid %b pkt %h required 1 %h", m_valid, m_pkt, p1); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bp_no_err: got %b required 0", err); end
        m_ready = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_push_pop_ready: got %b required 1", s_ready); end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        exp_cnt++;
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p2) begin n_bad++; $display("FAIL bp_order2: valid %b pkt %h required 1 %h", m_valid, m_pkt, p2); end
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt1: got %0d required %0d", pkt_cnt, exp_cnt); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p3) begin n_bad++; $display("FAIL bp_order3: valid %b pkt %h required 1 %h", m_valid, m_pkt, p3); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: m_valid %b required 0", m_valid); end
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt3: got %0d required %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_early_last();
        m_t p;
        p = mk(8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E, 5'h15);
        send_beat(8'hEE, 1'b0);
        send_beat(8'hEE, 1'b0);
        send_beat(8'hEE, 1'b1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL early_err: got %b required 1", err); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL early_after: err %b m_valid %b required 0 0", err, m_valid); end
        send_pkt(p, 1'b0);
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p) begin n_bad++; $display("FAIL early_next_pkt: valid %b pkt %h required 1 %h", m_valid, m_pkt, p); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL early_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_missing_last();
        m_t p, q;
        p = mk(8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 5'h03);
        q = mk(8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 5'h1C);
        for (int i = 0; i < 5; i++) send_beat(p.a[i], 1'b0);
        send_beat(tag_byte(p, 1'b0), 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL missing_err: got %b required 1", err); end
        send_beat(8'hDE, 1'b0);
        n_cmp++; if (err !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL missing_junk1: err %b m_valid %b required 0 0", err, m_valid); end
        send_beat(8'hAD, 1'b1);
        n_cmp++; if (err !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL missing_junk2: err %b m_valid %b required 0 0", err, m_valid); end
        send_pkt(q, 1'b0);
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== q) begin n_bad++; $display("FAIL missing_next_pkt: valid %b pkt %h required 1 %h", m_valid, m_pkt, q); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL missing_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
    endtask

`ifdef MT_UNPACK_PARITY_EN
    task automatic test_parity();
        m_t p;
        p = mk(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 5'h09);
        send_pkt(p, 1'b1);
        n_cmp++; if (err !== 1'b1 || m_valid !== 1'b0) begin n_bad++; $display("FAIL parity_bad: err %b m_valid %b required 1 0", err, m_valid); end
        @(posedge clk); #1;
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL parity_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
        send_pkt(p, 1'b0);
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p || err !== 1'b0) begin n_bad++; $display("FAIL parity_good: valid %b pkt %h err %b required 1 %h 0", m_valid, m_pkt, err, p); end
        @(posedge clk); #1;
        exp_cnt++;
    endtask
`endif

    task automatic test_reset_mid();
        m_t p;
        p = mk(8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 5'h0E);
        send_beat(8'h99, 1'b0);
        send_beat(8'h98, 1'b0);
        send_beat(8'h97, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0 || m_pkt !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_out: valid %b pkt %h err %b required 0 0 0", m_valid, m_pkt, err); end
        n_cmp++; if (pkt_cnt !== 16'd0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_cnt_rdy: cnt %0d s_ready %b required 0 1", pkt_cnt, s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        send_pkt(p, 1'b0);
        n_cmp++; if (m_valid !== 1'b1 || m_pkt !== p) begin n_bad++; $display("FAIL rstmid_next_pkt: valid %b pkt %h required 1 %h", m_valid, m_pkt, p); end
        @(posedge clk); #1;
        exp_cnt++;
        n_cmp++; if (pkt_cnt !== exp_cnt) begin n_bad++; $display("FAIL rstmid_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_early_last();
        test_missing_last();
`ifdef MT_UNPACK_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mt_unpacker.md
MT_UNPACKER -- requirements
Module: mt_unpacker

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 5, meaning the number of payload bytes per packet; it SHALL equal the length of field a in mytest::m_t.
REQ-002 SHALL have parameter OUT_DEPTH, default 2, meaning the number of output buffer entries; legal values are 1 and 2.
REQ-003 SHALL have the ports below; the clock and reset are `clk` and `rst_n`, with one clock and an asynchronous active-low reset.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  byte beat valid.
- s_ready  out  1  byte beat accepted when s_valid&&s_ready.
- s_data  in  8  beat payload.
- s_last  in  1  marks the tag beat, the final beat of a packet.
- m_valid  out  1  assembled packet valid.
- m_ready  in  1  downstream accept.
- m_pkt  out  mytest::m_t  assembled packet.
- err  out  1  one-cycle pulse on a dropped packet.
- pkt_cnt  out  16  count of packets delivered on m.

Function
REQ-004 SHALL assemble each packet from NUM_BYTES+1 beats: beat i (i<NUM_BYTES) -> a[i]; beat NUM_BYTES -> b = s_data[4:0].
REQ-005 SHALL implement the FSM COLLECT -> TAG -> COLLECT with a beat counter 0..NUM_BYTES-1.
- COLLECT counts payload beats and moves to TAG after beat NUM_BYTES-1.
- TAG pushes the packet and returns to COLLECT.
REQ-006 SHALL detect framing errors:
- s_last=1 on a payload beat: drop the partial packet, pulse err, go to COLLECT with the counter at 0.
- s_last=0 on the tag beat: drop the packet, pulse err, go to RESYNC.
- RESYNC discards beats until a beat with s_last=1 is accepted, then returns to COLLECT.
REQ-007 SHALL hold s_ready=1 except in TAG while the output buffer is full; in RESYNC s_ready SHALL be 1.
REQ-008 SHALL present a completed packet on m_valid the cycle after its tag beat is accepted (latency 1).
REQ-009 SHALL keep m_pkt and m_valid stable while m_valid&&!m_ready.
REQ-010 SHALL allow a push and a pop in the same cycle when the buffer is full, with no bubble and no loss at OUT_DEPTH=2.
REQ-011 SHALL increment pkt_cnt on each m_valid&&m_ready and wrap 0xFFFF->0x0000.
REQ-012 SHALL never pulse err for back-pressure stalls.

Reset
REQ-013 SHALL, on rst_n low, immediately set state COLLECT, counter 0, buffer empty, m_valid=0, m_pkt=0, err=0, pkt_cnt=0 and s_ready=1.
REQ-014 SHALL discard any partial or buffered packet on reset mid-operation; it SHALL not emit err for it.

Configuration
REQ-015 SHALL, with MT_UNPACK_PARITY_EN defined, treat tag-beat s_data[7] as even parity over all payload bytes and b[4:0]; on mismatch it SHALL drop the packet and pulse err.
REQ-016 SHALL, without MT_UNPACK_PARITY_EN, ignore s_data[7:5] of the tag beat and contain no parity logic.

Structure
REQ-017 SHALL take m_t and the constants MT_NUM_BYTES=5 and MT_TAG_W=5 from package mytest.
REQ-018 SHALL place the FSM state enum in mytest.
REQ-019 SHALL implement the output buffer as sub-module mt_skid_buf, parameterised by depth and type.

Verification
REQ-020 SHALL cover the single packet case: beats 11,22,33,44,55 then tag 0x0A with last -> m_pkt.a={11,22,33,44,55}, b=0x0A one cycle later, pkt_cnt=1.
REQ-021 SHALL cover back-pressure: m_ready=0 for 3 packets with OUT_DEPTH=2 -> s_ready drops in TAG of packet 3, no data loss, and the packets are delivered in order once m_ready=1.
REQ-022 SHALL cover early last: s_last on beat 2 -> err pulse, no m_valid, next full packet received correctly.
REQ-023 SHALL cover missing last: tag beat with s_last=0, then 2 junk beats, the last with s_last=1 -> one err pulse, junk discarded, next packet correct.
REQ-024 SHALL cover parity with MT_UNPACK_PARITY_EN: flipped parity bit -> err, packet dropped, pkt_cnt unchanged; correct parity -> delivered.
REQ-025 SHALL cover reset mid-packet: rst_n low after beat 3 -> all outputs at reset values; the following packet is assembled from beat 0.
